muldiv: RTL and testbench
=========================

# muldiv

Multi-cycle RV32M multiply/divide unit in the EX stage, beside the combinational ALU, sharing its operand sources and result width (`CPU_WIDTH`). It takes an M-extension operation with a start pulse, iterates one bit per cycle, and returns a 32-bit result with a one-cycle done pulse. Pipeline control stalls on `md_busy` and writes back `md_res` on `md_done`.

## Interface
- `CPU_WIDTH`: default 32. Data width; the iteration count equals `CPU_WIDTH`.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `md_start` in 1: start request, sampled only in IDLE.
- `md_op` in 3: operation, encoded as funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `md_src1` in `CPU_WIDTH`: rs1 operand (multiplicand/dividend).
- `md_src2` in `CPU_WIDTH`: rs2 operand (multiplier/divisor).
- `md_flush` in 1: synchronous kill of the operation in flight.
- `md_busy` out 1: high in CALC and DONE.
- `md_done` out 1: one-cycle pulse; `md_res` is valid in this cycle.
- `md_res` out `CPU_WIDTH`: registered result, held until the next done.

## Operation
- States: IDLE, CALC, DONE.
- IDLE with `md_start`=1:
  - Latch the op and operands.
  - Compute sign flags and magnitudes.
  - Clear `cnt`, then go to CALC.
- IDLE with a special division case goes directly to DONE with the fixed result:
  - DIV/DIVU/REM/REMU with `md_src2`=0: quotient = all ones; remainder = `md_src1`.
  - DIV/REM with `md_src1`=0x80000000 and `md_src2`=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- CALC performs one iteration per cycle, `cnt` 0..31. At `cnt`=31 → DONE.
  - Multiply: unsigned shift-add, 64-bit accumulator.
  - Divide: restoring, 32-bit partial remainder plus quotient shift register.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Sign fix-up is applied when entering DONE:
  - Product is negated (64-bit two's complement) if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Result selection: MUL takes product[31:0]; MULH/MULHSU/MULHU take product[63:32]; DIV/DIVU take the quotient; REM/REMU take the remainder.
- DONE: `md_done`=1 for exactly one cycle, then → IDLE.
- `md_start` while busy: ignored, no queuing.
- `md_flush`:
  - From any state → IDLE at the next edge. No done pulse; `md_res` unchanged.
  - Flush has priority over start in the same cycle.
- Reset values: state IDLE, `md_busy`=0, `md_done`=0, `md_res`=0, `cnt`=0. Reset mid-operation aborts it with no done pulse.

## Timing
- Start sampled in cycle 0:
  - `md_busy`=1 in cycles 1..33.
  - CALC in cycles 1..32.
  - `md_done`=1 and `md_res` valid in cycle 33.
  - IDLE again in cycle 34.
- Special division cases: `md_done` in cycle 1, `md_busy`=1 in cycle 1 only.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE. Throughput is one operation per 34 cycles.
- `md_busy` and `md_done` are registered state decodes, with no combinational path from inputs.
- Operands need not be held after the start cycle.

## Structure
- Add the shared constants to `defines.v`:
  - `MD_OP_WIDTH` (3).
  - `MD_MUL`, `MD_MULH`, `MD_MULHSU`, `MD_MULHU`, `MD_DIV`, `MD_DIVU`, `MD_REM`, `MD_REMU`.
  - The state encodings `MD_IDLE`, `MD_CALC`, `MD_DONE`.
- One sub-module is natural: `md_signfix`, combinational operand magnitude and result negation, instantiated once for input and once for output fix-up. The FSM and the iteration datapath stay in `muldiv`.

## Test plan
- MUL, 7 × 0xFFFFFFFD (−3), start in cycle 0 → `md_done` in cycle 33 only, `md_res`=0xFFFFFFEB, `md_busy` high for cycles 1..33.
- Signed/unsigned high products, 0x80000000 × 0x80000000:
  - MULH → 0x40000000.
  - MULHU → 0x40000000.
  - MULHSU → 0xC0000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Signed division, −7 / 2: DIV → 0xFFFFFFFD, REM → 0xFFFFFFFF. Unsigned: DIVU 100/7 → 14, REMU → 2.
- Division corner cases:
  - DIVU 0x1234 / 0 → 0xFFFFFFFF, done in cycle 1.
  - REM 0x1234 / 0 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Flush, ignored start, and reset:
  - Assert `md_flush` in cycle 10 of a DIV → no done pulse, `md_busy`=0 in cycle 11, `md_res` keeps its prior value.
  - Start in cycle 11 completes normally, done in cycle 44.
  - `md_start` during CALC is ignored.
  - `rst` mid-CALC → all outputs return to 0.
- Back-to-back: MUL then DIVU, with the second start in the cycle after done → second done exactly 34 cycles after the first.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared opcodes, state encoding and helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int MD_OP_WIDTH = 3;

  localparam logic [MD_OP_WIDTH-1:0] MD_MUL    = 3'd0;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULH   = 3'd1;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULHSU = 3'd2;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULHU  = 3'd3;
  localparam logic [MD_OP_WIDTH-1:0] MD_DIV    = 3'd4;
  localparam logic [MD_OP_WIDTH-1:0] MD_DIVU   = 3'd5;
  localparam logic [MD_OP_WIDTH-1:0] MD_REM    = 3'd6;
  localparam logic [MD_OP_WIDTH-1:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic md_is_div(input logic [MD_OP_WIDTH-1:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/md_signfix.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fix-up.
module md_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv.sv
// Multi-cycle RV32M multiply/divide: one shift-add or restoring-divide step per cycle,
// unsigned core with sign handling on the way in and on the way out.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int CPU_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   md_start,
  input  logic [MD_OP_WIDTH-1:0] md_op,
  input  logic [CPU_WIDTH-1:0]   md_src1,
  input  logic [CPU_WIDTH-1:0]   md_src2,
  input  logic                   md_flush,
  output logic                   md_busy,
  output logic                   md_done,
  output logic [CPU_WIDTH-1:0]   md_res
);

  localparam int CNT_W = $clog2(CPU_WIDTH);
  localparam int W2    = 2 * CPU_WIDTH;

  md_state_t              state;
  logic [MD_OP_WIDTH-1:0] op_q;
  logic                   neg_q;
  logic [CPU_WIDTH-1:0]   divisor_q;
  logic [W2-1:0]          acc_q;
  logic [W2-1:0]          acc_next;
  logic [CNT_W-1:0]       cnt;

  logic                   src1_signed, src2_signed;
  logic                   src1_neg, src2_neg, res_neg;
  logic [CPU_WIDTH-1:0]   src1_mag, src2_mag;
  logic                   div_by_zero, div_ovf;
  logic [CPU_WIDTH-1:0]   special_res;
  logic [CPU_WIDTH:0]     add_sum, trial;
  logic [W2-1:0]          fix_in, fix_out;
  logic [CPU_WIDTH-1:0]   res_final;

  assign src1_signed = !(md_op == MD_MULHU || md_op == MD_DIVU || md_op == MD_REMU);
  assign src2_signed = (md_op == MD_MUL || md_op == MD_MULH || md_op == MD_DIV || md_op == MD_REM);
  assign src1_neg    = src1_signed & md_src1[CPU_WIDTH-1];
  assign src2_neg    = src2_signed & md_src2[CPU_WIDTH-1];
  // Remainder follows the dividend; products and quotients follow the sign product
  assign res_neg     = (md_op == MD_REM || md_op == MD_REMU) ? src1_neg : (src1_neg ^ src2_neg);

  md_signfix #(.WIDTH(CPU_WIDTH)) u_fix_src1 (.value(md_src1), .negate(src1_neg), .result(src1_mag));
  md_signfix #(.WIDTH(CPU_WIDTH)) u_fix_src2 (.value(md_src2), .negate(src2_neg), .result(src2_mag));

  assign div_by_zero = md_is_div(md_op) && (md_src2 == '0);
  assign div_ovf     = (md_op == MD_DIV || md_op == MD_REM) &&
                       (md_src1 == {1'b1, {(CPU_WIDTH-1){1'b0}}}) && (md_src2 == '1);
  assign special_res = div_by_zero ? (md_op[1] ? md_src1 : '1)
                                   : (md_op[1] ? '0 : {1'b1, {(CPU_WIDTH-1){1'b0}}});

  // acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    add_sum  = '0;
    trial    = '0;
    acc_next = acc_q;
    if (!md_is_div(op_q)) begin
      add_sum  = {1'b0, acc_q[W2-1:CPU_WIDTH]} + (acc_q[0] ? {1'b0, divisor_q} : '0);
      acc_next = {add_sum, acc_q[CPU_WIDTH-1:1]};
    end else begin
      trial = acc_q[W2-1:CPU_WIDTH-1] - {1'b0, divisor_q};
      if (!trial[CPU_WIDTH])
        acc_next = {trial[CPU_WIDTH-1:0], acc_q[CPU_WIDTH-2:0], 1'b1};
      else
        acc_next = {acc_q[W2-2:0], 1'b0};
    end
  end

  assign fix_in = md_is_div(op_q)
                ? {{CPU_WIDTH{1'b0}}, (op_q[1] ? acc_next[W2-1:CPU_WIDTH] : acc_next[CPU_WIDTH-1:0])}
                : acc_next;

  md_signfix #(.WIDTH(W2)) u_fix_res (.value(fix_in), .negate(neg_q), .result(fix_out));

  assign res_final = (op_q == MD_MUL || md_is_div(op_q)) ? fix_out[CPU_WIDTH-1:0]
                                                         : fix_out[W2-1:CPU_WIDTH];

  // Flush outranks everything but reset, and never produces a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MD_IDLE;
      md_busy   <= 1'b0;
      md_done   <= 1'b0;
      md_res    <= '0;
      cnt       <= '0;
      acc_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      divisor_q <= '0;
    end else if (md_flush) begin
      state   <= MD_IDLE;
      md_busy <= 1'b0;
      md_done <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          md_done <= 1'b0;
          if (md_start) begin
            op_q    <= md_op;
            neg_q   <= res_neg;
            cnt     <= '0;
            md_busy <= 1'b1;
            if (div_by_zero || div_ovf) begin
              md_res  <= special_res;
              md_done <= 1'b1;
              state   <= MD_DONE;
            end else begin
              divisor_q <= src2_mag;
              acc_q     <= {{CPU_WIDTH{1'b0}}, src1_mag};
              state     <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          acc_q <= acc_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(CPU_WIDTH - 1)) begin
            md_res  <= res_final;
            md_done <= 1'b1;
            state   <= MD_DONE;
          end
        end
        MD_DONE: begin
          md_done <= 1'b0;
          md_busy <= 1'b0;
          state   <= MD_IDLE;
        end
        default: begin
          md_done <= 1'b0;
          md_busy <= 1'b0;
          state   <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Directed self-checking bench for muldiv: arithmetic results, latency, corner cases,
// flush, ignored start, reset and back-to-back throughput.
module tb_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        md_start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] md_src1 = 32'd0;
  logic [31:0] md_src2 = 32'd0;
  logic        md_flush = 1'b0;
  logic        md_busy;
  logic        md_done;
  logic [31:0] md_res;

  int checks = 0;
  int errors = 0;

  muldiv #(.CPU_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start),
    .md_op    (md_op),
    .md_src1  (md_src1),
    .md_src2  (md_src2),
    .md_flush (md_flush),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .md_res   (md_res)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives a start pulse in the current cycle (cycle 0 of the operation)
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_start = 1'b1;
    md_op    = op;
    md_src1  = a;
    md_src2  = b;
  endtask

  // Steps until done (bounded); lat=-1 on timeout. Optionally pokes a second start at poke_cycle.
  task automatic waitDone(input int poke_cycle, output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == poke_cycle) begin
        md_start = 1'b1;
        md_op    = MD_DIVU;
        md_src1  = 32'd100;
        md_src2  = 32'd7;
      end else begin
        md_start = 1'b0;
        md_src1  = $urandom;
        md_src2  = $urandom;
      end
      if (md_busy) busy_cnt++;
      if (md_done) begin
        lat = i;
        break;
      end
    end
    md_start = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expected, input int exp_lat);
    int lat, busy_cnt;
    applyStimulus(op, a, b);
    waitDone(0, lat, busy_cnt);
    checkOutput({tag, " res"}, md_res, expected);
    checkOutput({tag, " latency"}, lat, exp_lat);
    step();
    checkOutput({tag, " done pulse width"}, {31'd0, md_done}, 32'd0);
  endtask

  initial begin
    int lat, busy_cnt, lat2, b2;
    bit saw_done;

    step(); step(); step();
    rst = 1'b0;
    checkOutput("reset busy", {31'd0, md_busy}, 32'd0);
    checkOutput("reset done", {31'd0, md_done}, 32'd0);
    checkOutput("reset res", md_res, 32'd0);
    step();

    applyStimulus(MD_MUL, 32'd7, 32'hFFFF_FFFD);
    waitDone(0, lat, busy_cnt);
    checkOutput("mul res", md_res, 32'hFFFF_FFEB);
    checkOutput("mul done cycle", lat, 33);
    checkOutput("mul busy cycles", busy_cnt, 33);
    step();
    checkOutput("mul done one cycle", {31'd0, md_done}, 32'd0);
    checkOutput("mul busy drops", {31'd0, md_busy}, 32'd0);

    runOp("mulh min*min",   MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    runOp("mulhu min*min",  MD_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    runOp("mulhsu min*min", MD_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 33);
    runOp("mulhu max*max",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    runOp("div -7/2",       MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    runOp("rem -7/2",       MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    runOp("divu 100/7",     MD_DIVU,   32'd100,       32'd7,         32'd14,        33);
    runOp("remu 100/7",     MD_REMU,   32'd100,       32'd7,         32'd2,         33);

    applyStimulus(MD_DIVU, 32'h1234, 32'd0);
    waitDone(0, lat, busy_cnt);
    checkOutput("divu by zero res", md_res, 32'hFFFF_FFFF);
    checkOutput("divu by zero done cycle", lat, 1);
    checkOutput("divu by zero busy cycles", busy_cnt, 1);
    step();
    checkOutput("divu by zero busy drops", {31'd0, md_busy}, 32'd0);

    runOp("rem by zero",  MD_REM, 32'h1234,      32'd0,         32'h1234,      1);
    runOp("div overflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

    // Flush a DIV in cycle 10; prior result 0x80000000 must survive
    applyStimulus(MD_DIV, 32'd100, 32'd7);
    saw_done = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      md_start = 1'b0;
      if (md_done) saw_done = 1'b1;
    end
    md_flush = 1'b1;
    step();
    md_flush = 1'b0;
    if (md_done) saw_done = 1'b1;
    checkOutput("flush no done", {31'd0, saw_done}, 32'd0);
    checkOutput("flush busy cleared", {31'd0, md_busy}, 32'd0);
    checkOutput("flush res held", md_res, 32'h8000_0000);
    applyStimulus(MD_DIV, 32'd100, 32'd7);
    waitDone(0, lat, busy_cnt);
    checkOutput("post-flush res", md_res, 32'd14);
    checkOutput("post-flush done cycle", 11 + lat, 44);
    step();

    runOp("rem overflow", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    applyStimulus(MD_MUL, 32'd3, 32'd5);
    waitDone(5, lat, busy_cnt);
    checkOutput("start during calc res", md_res, 32'd15);
    checkOutput("start during calc done cycle", lat, 33);
    step();
    checkOutput("start during calc idle", {31'd0, md_busy}, 32'd0);

    applyStimulus(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      step();
      md_start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mid-calc reset busy", {31'd0, md_busy}, 32'd0);
    checkOutput("mid-calc reset done", {31'd0, md_done}, 32'd0);
    checkOutput("mid-calc reset res", md_res, 32'd0);
    waitDone(0, lat, busy_cnt);
    checkOutput("no done after reset", lat, -1);

    applyStimulus(MD_MUL, 32'd12, 32'd11);
    waitDone(0, lat, busy_cnt);
    checkOutput("b2b mul res", md_res, 32'd132);
    step();
    applyStimulus(MD_DIVU, 32'd1000, 32'd9);
    waitDone(0, lat2, b2);
    checkOutput("b2b divu res", md_res, 32'd111);
    checkOutput("b2b done spacing", 1 + lat2, 34);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
